trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer between the WB stage and the CSR file, which has a single write port.
- Accepts synchronous exceptions, `mret` and the three M-mode interrupts, then performs the required CSR updates one write per cycle.
- Stalls the pipeline during the sequence, then issues a single-cycle flush and PC redirect.
- Also forwards ordinary CSR-instruction writes to the CSR write port when idle.

Parameters:
- XLEN, 64, data/PC width.
- CSR_MEPC, 12'h341, MEPC address.
- CSR_MCAUSE, 12'h342, MCAUSE address.
- CSR_MTVAL, 12'h343, MTVAL address.
- CSR_MSTATUS, 12'h300, MSTATUS address.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- exc_valid_i  in  1  WB instruction raised an exception.
- exc_cause_i  in  64  exception code.
- exc_pc_i  in  64  PC of faulting instruction.
- exc_tval_i  in  64  trap value.
- mret_i  in  1  WB instruction is `mret`.
- wb_valid_i  in  1  valid instruction in WB (interrupt boundary).
- wb_pc_i  in  64  PC of WB instruction.
- irq_meip_i / irq_msip_i / irq_mtip_i  in  1 each  interrupt pending lines.
- csr_instr_wen_i  in  1  CSR-instruction write request.
- csr_instr_waddr_i  in  12  its address.
- csr_instr_wdata_i  in  64  its data.
- mstatus_i, mie_i, mtvec_i, mepc_i  in  64 each  current CSR values (combinational CSR-file reads).
- csr_wen_o  out  1  CSR write enable.
- csr_waddr_o  out  12  CSR write address.
- csr_wdata_o  out  64  CSR write data.
- kill_wb_o  out  1  combinational; suppress WB retirement this cycle.
- stall_o  out  1  freeze all pipeline stages.
- flush_o  out  1  squash IF..WB.
- redirect_valid_o  out  1  load new PC.
- redirect_pc_o  out  64  target PC.
- busy_o  out  1  FSM not IDLE.

Behaviour:
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, M_MSTATUS, REDIRECT.
- Reset (async, any state, including mid-sequence): state=IDLE; captured epc/cause/tval and the trap/mret flag cleared; every output 0. No partial CSR write completes after reset asserts.
- Interrupt pending:
  - `ip = {meip,msip,mtip} & {mie_i[11],mie_i[3],mie_i[7]}`, gated by `mstatus_i[3]` (MIE).
  - Priority MEI(11) > MSI(3) > MTI(7).
  - Interrupt cause = {1'b1, 63'd code}.
- IDLE acceptance, priority exc_valid_i > mret_i > (wb_valid_i && ip != 0). Acceptance cycle is T:
  - Exception: capture epc=exc_pc_i, cause=exc_cause_i (MSB 0), tval=exc_tval_i; next state W_MEPC.
  - Interrupt: capture epc=wb_pc_i, cause as above, tval=0; kill_wb_o=1 in cycle T (WB instruction not executed, re-executed after return); next state W_MEPC.
  - mret: next state M_MSTATUS.
  - On any acceptance, a same-cycle csr_instr_wen_i is dropped (csr_wen_o=0).
  - No acceptance: csr_wen_o/waddr/wdata pass through the csr_instr_* inputs combinationally.
- Trap sequence (registered csr_* outputs):
  - T+1 W_MEPC: write epc.
  - T+2 W_MCAUSE: write cause.
  - T+3 W_MTVAL: write tval.
  - T+4 W_MSTATUS: write mstatus_i with MPIE(7)<=MIE(3), MIE(3)<=0, MPP(12:11)<=2'b11.
  - T+5 REDIRECT.
- mret sequence:
  - T+1 M_MSTATUS: write mstatus_i with MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - T+2 REDIRECT.
- REDIRECT (1 cycle): csr_wen_o=0, flush_o=1, redirect_valid_o=1; next state IDLE.
  - Trap target:
    - mtvec_i[1:0]==0: {mtvec_i[63:2],2'b00}.
    - mtvec_i[1:0]==1 and interrupt: base + 4*code.
    - mtvec_i[1:0]==1 and exception: base.
    - mtvec_i[1:0] of 2 or 3: treated as direct.
  - mret target: {mepc_i[63:1],1'b0}.
- stall_o=busy_o=1 in every non-IDLE state, including REDIRECT.
- Events arriving while busy (exceptions, mret, interrupts, csr_instr writes) are ignored. Pipeline stall guarantees none arrive; the bench asserts this.
- Interrupt lines are level-sensitive and re-evaluated only in IDLE. Interrupts are masked after a trap because the MSTATUS write clears MIE.
- Back-to-back: the cycle after REDIRECT is IDLE and may accept a new event.

Test Plan:
- Exception: mtvec=0x8000_0000, exc_valid_i=1, cause=2, pc=0x8000_0100, tval=0xDEAD -> writes at T+1..T+4 are 0x341=0x8000_0100, 0x342=2, 0x343=0xDEAD, 0x300 with MIE=0/MPIE=old MIE/MPP=3. T+5: flush=1, redirect_pc=0x8000_0000. Stall high T+1..T+5.
- Vectored interrupt: mtvec=0x8000_0001, mstatus.MIE=1, mie[7]=1, mtip=1, wb_valid_i=1, wb_pc=0x8000_0040 -> kill_wb_o=1 at T. MEPC=0x8000_0040, MCAUSE=0x8000_0000_0000_0007, redirect_pc=0x8000_001C.
- Priority: meip, msip, mtip all pending and enabled, plus exc_valid_i in the same cycle -> exception taken. With exc_valid_i=0 -> cause code 11.
- mret: mstatus MPIE=1, MIE=0, mepc=0x8000_0105 -> T+1 writes mstatus with MIE=1, MPIE=1. T+2 redirect_pc=0x8000_0104.
- Passthrough and collision: csr_instr write 0x305=0x1234 in IDLE -> csr_wen_o same cycle with identical addr/data. Same write coinciding with exc_valid_i -> dropped.
- Reset at T+2 of a trap -> all outputs 0 immediately, IDLE. After release, no further CSR writes occur and a new exception is accepted normally.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: serialises MEPC/MCAUSE/MTVAL/MSTATUS
// updates through one CSR write port, then flushes and redirects.
module trap_ctrl #(
  parameter int          XLEN        = 64,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342,
  parameter logic [11:0] CSR_MTVAL   = 12'h343,
  parameter logic [11:0] CSR_MSTATUS = 12'h300
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic            wb_valid_i,
  input  logic [XLEN-1:0] wb_pc_i,
  input  logic            irq_meip_i,
  input  logic            irq_msip_i,
  input  logic            irq_mtip_i,
  input  logic            csr_instr_wen_i,
  input  logic [11:0]     csr_instr_waddr_i,
  input  logic [XLEN-1:0] csr_instr_wdata_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_wen_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            kill_wb_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL,
    W_MSTATUS, M_MSTATUS, REDIRECT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            irq_q, irq_d;
  logic            mret_q, mret_d;

  logic            irq_hit;
  logic [5:0]      irq_code;
  logic [XLEN-1:0] ms_trap;
  logic [XLEN-1:0] ms_mret;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] trap_pc;

  logic unused_ok;
  assign unused_ok = ^{mie_i[XLEN-1:12], mie_i[10:8],
                       mie_i[6:4], mie_i[2:0], mepc_i[0]};

  // Highest-priority enabled interrupt: MEI > MSI > MTI
  always_comb begin
    irq_hit  = 1'b0;
    irq_code = 6'd0;
    if (mstatus_i[3]) begin
      if (irq_meip_i && mie_i[11]) begin
        irq_hit  = 1'b1;
        irq_code = 6'd11;
      end else if (irq_msip_i && mie_i[3]) begin
        irq_hit  = 1'b1;
        irq_code = 6'd3;
      end else if (irq_mtip_i && mie_i[7]) begin
        irq_hit  = 1'b1;
        irq_code = 6'd7;
      end
    end
  end

  // MSTATUS images for trap entry / mret and the trap target PC
  always_comb begin
    ms_trap        = mstatus_i;
    ms_trap[7]     = mstatus_i[3];
    ms_trap[3]     = 1'b0;
    ms_trap[12:11] = 2'b11;
    ms_mret        = mstatus_i;
    ms_mret[3]     = mstatus_i[7];
    ms_mret[7]     = 1'b1;
    ms_mret[12:11] = 2'b11;
    tvec_base      = {mtvec_i[XLEN-1:2], 2'b00};
    if (mtvec_i[1:0] == 2'b01 && irq_q)
      trap_pc = tvec_base +
                {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
    else
      trap_pc = tvec_base;
  end

  // Next state, captured trap info and all outputs
  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    tval_d           = tval_q;
    irq_d            = irq_q;
    mret_d           = mret_q;
    csr_wen_o        = 1'b0;
    csr_waddr_o      = 12'd0;
    csr_wdata_o      = '0;
    kill_wb_o        = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    busy_o           = (state_q != IDLE);
    stall_o          = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        // outputs stay quiet while reset is held
        if (reset_n) begin
          if (exc_valid_i) begin
            epc_d   = exc_pc_i;
            cause_d = exc_cause_i;
            tval_d  = exc_tval_i;
            irq_d   = 1'b0;
            mret_d  = 1'b0;
            state_d = W_MEPC;
          end else if (mret_i) begin
            irq_d   = 1'b0;
            mret_d  = 1'b1;
            state_d = M_MSTATUS;
          end else if (wb_valid_i && irq_hit) begin
            epc_d     = wb_pc_i;
            cause_d   = {1'b1, {(XLEN-7){1'b0}}, irq_code};
            tval_d    = '0;
            irq_d     = 1'b1;
            mret_d    = 1'b0;
            kill_wb_o = 1'b1;
            state_d   = W_MEPC;
          end else begin
            csr_wen_o   = csr_instr_wen_i;
            csr_waddr_o = csr_instr_waddr_i;
            csr_wdata_o = csr_instr_wdata_i;
          end
        end
      end
      W_MEPC: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_q;
        state_d     = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
        state_d     = W_MTVAL;
      end
      W_MTVAL: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MTVAL;
        csr_wdata_o = tval_q;
        state_d     = W_MSTATUS;
      end
      W_MSTATUS: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = ms_trap;
        state_d     = REDIRECT;
      end
      M_MSTATUS: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = ms_mret;
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        flush_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mret_q ?
                           {mepc_i[XLEN-1:1], 1'b0} : trap_pc;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured trap registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      irq_q   <= 1'b0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      irq_q   <= irq_d;
      mret_q  <= mret_d;
    end
  end

endmodule
